bpt_update_ctrl: RTL

- Resolves each ID-stage branch against the prediction made at fetch.
- Drives a one-cycle pipeline flush and PC redirect on a mispredict.
- Buffers the resulting table updates in a small FIFO and owns the single write port of the branch prediction table.
- Also sequences a full table invalidation (walk of all entries) on request, arbitrating it against pending updates.

---
 rtl/bp_pkg.sv | 29 ++
 rtl/bpt_upd_fifo.sv | 74 +++++++
 rtl/bpt_update_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared types and constants for the branch prediction table update controller.
package bp_pkg;

    // Opcode of a conditional branch (B-type).
    localparam logic [6:0] BRANCH_OP = 7'b1100011;

    // Widest table index an update record can carry. Narrower tables
    // leave the upper bits at zero.
    localparam int IDX_W_MAX = 16;

    // Controller states: normal update draining, or a full-table invalidation walk.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } bpt_state_e;

    // One pending table update, as queued in the update FIFO.
    typedef struct packed {
        logic [IDX_W_MAX-1:0] idx;
        logic [63:0]          target;
        logic                 taken;
    } bpt_upd_t;

    // Sequential fetch address after a not-taken branch (64-bit wrap).
    function automatic logic [63:0] next_seq_pc(input logic [63:0] pc);
        return pc + 64'd4;
    endfunction

endpackage

// File: rtl/bpt_upd_fifo.sv
// Small synchronous FIFO of table-update records. The head is visible
// combinationally so the consumer can write it in the same cycle it pops.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module bpt_upd_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH)
)(
    input  logic           clk,
    input  logic           arst,
    input  logic           push,
    input  bpt_upd_t       push_rec,
    input  logic           pop,
    output bpt_upd_t       head_rec,
    output logic           full,
    output logic           empty,
    output logic [PTR_W:0] count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    bpt_upd_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    // Qualify push/pop against occupancy and advance pointers and count.
    always_comb begin
        do_pop   = pop & (count_q != '0);
        do_push  = push & ((count_q != FULL_CNT) | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Record storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_rec;
        end
    end

    assign head_rec = mem_q[rd_ptr_q];
    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/bpt_update_ctrl.sv
// Branch resolution and prediction-table update controller.
// Compares each ID-stage branch against its fetch-time prediction, issues a
// one-cycle flush/redirect on a mispredict, queues table updates and owns
// the table write port, interleaving a full invalidation walk on request.
module bpt_update_ctrl
    import bp_pkg::*;
#(
    parameter int N_REG      = 4,
    parameter int N_BITS     = $clog2(N_REG),
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 32
)(
    input  logic              clk,
    input  logic              arst,
    input  logic              id_valid,
    input  logic              id_is_branch,
    input  logic              id_pred_taken,
    input  logic              id_taken,
    input  logic [63:0]       id_pc,
    input  logic [63:0]       id_target,
    input  logic              clear_req,
    output logic              stall,
    output logic              flush,
    output logic [63:0]       redirect_pc,
    output logic              tbl_we,
    output logic [N_BITS-1:0] tbl_idx,
    output logic              tbl_clr,
    output logic [63:0]       tbl_target,
    output logic              tbl_taken,
    output logic              clear_busy,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  mispred_cnt
);

    localparam int                FIFO_PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [N_BITS-1:0] LAST_IDX   = N_BITS'(N_REG - 1);

    bpt_state_e        state_q, state_d;
    logic [N_BITS-1:0] walk_q, walk_d;
    logic              flush_q, flush_d;
    logic [63:0]       redirect_q, redirect_d;
    logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]  mispred_cnt_q, mispred_cnt_d;

    logic              acc, mp, pop, stall_int;
    logic [N_BITS-1:0] id_idx;
    bpt_upd_t          push_rec, head_rec;
    logic              fifo_full, fifo_empty;
    logic [FIFO_PTR_W:0] fifo_count_unused;

    // Same index slice the table uses for lookup.
    assign id_idx = id_pc[2*N_BITS-1:N_BITS];

    // Pop only when idle and no clear is starting; a full FIFO that is
    // popping this cycle can still take a new branch.
    assign pop       = (state_q == ST_IDLE) & ~clear_req & ~fifo_empty;
    assign stall_int = fifo_full & ~pop;
    assign acc       = id_valid & id_is_branch & ~flush_q & ~stall_int;
    assign mp        = acc & (id_pred_taken ^ id_taken);

    // Build the update record for an accepted branch.
    always_comb begin
        push_rec                    = '0;
        push_rec.idx[N_BITS-1:0]    = id_idx;
        push_rec.target             = id_target;
        push_rec.taken              = id_taken;
    end

    bpt_upd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .arst     (arst),
        .push     (acc),
        .push_rec (push_rec),
        .pop      (pop),
        .head_rec (head_rec),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count_unused)
    );

    // Upper record index bits are always zero for this table size.
    generate
        if (N_BITS < IDX_W_MAX) begin : g_idx_hi
            logic unused_idx_hi;
            assign unused_idx_hi = ^head_rec.idx[IDX_W_MAX-1:N_BITS];
        end
    endgenerate

    // FSM next state and table write port: walk entries in CLEAR, otherwise
    // drain the FIFO head straight onto the write port.
    always_comb begin
        state_d    = state_q;
        walk_d     = walk_q;
        tbl_we     = 1'b0;
        tbl_clr    = 1'b0;
        tbl_idx    = '0;
        tbl_target = '0;
        tbl_taken  = 1'b0;
        clear_busy = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    walk_d  = '0;
                end else if (!fifo_empty) begin
                    tbl_we     = 1'b1;
                    tbl_idx    = head_rec.idx[N_BITS-1:0];
                    tbl_target = head_rec.target;
                    tbl_taken  = head_rec.taken;
                end
            end
            ST_CLEAR: begin
                tbl_we     = 1'b1;
                tbl_clr    = 1'b1;
                tbl_idx    = walk_q;
                clear_busy = 1'b1;
                if (walk_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    walk_d  = '0;
                end else begin
                    walk_d = walk_q + N_BITS'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                walk_d  = '0;
            end
        endcase
    end

    // Mispredict redirect and saturating statistics counters.
    always_comb begin
        flush_d       = mp;
        redirect_d    = '0;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (mp) begin
            redirect_d = id_taken ? id_target : next_seq_pc(id_pc);
        end
        if (acc && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end
        if (mp && (mispred_cnt_q != '1)) begin
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset discards any walk in progress.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q       <= ST_IDLE;
            walk_q        <= '0;
            flush_q       <= 1'b0;
            redirect_q    <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            walk_q        <= walk_d;
            flush_q       <= flush_d;
            redirect_q    <= redirect_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign stall       = stall_int;
    assign flush       = flush_q;
    assign redirect_pc = redirect_q;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule
